// File: rtl/mulred_sched.sv
// Scheduler sharing one multiplier/reducer pair between two requesters.
// Each job runs multiply then reduce; a wait counter aborts stuck engine waits.
module mulred_sched #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [255:0] a0,
  input  logic [255:0] b0,
  input  logic [255:0] a1,
  input  logic [255:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [255:0] res,
  output logic         busy,
  output logic         err,
  output logic         mul_start,
  output logic [255:0] mul_a,
  output logic [255:0] mul_b,
  input  logic         mul_busy,
  input  logic [511:0] mul_c,
  output logic         red_start,
  output logic [511:0] red_a,
  input  logic         red_busy,
  input  logic [255:0] red_b
);

  typedef enum logic [2:0] {
    IDLE, MUL_W1, MUL_WAIT, RED_GO, RED_W1, RED_WAIT, DONE
  } state_t;

  // Abort fires at the end of the TIMEOUT-th cycle spent in a wait state.
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;
  logic          mul_start_q, mul_start_d;
  logic          red_start_q, red_start_d;
  logic [255:0]  res_q, res_d;
  logic [255:0]  mul_a_q, mul_a_d;
  logic [255:0]  mul_b_q, mul_b_d;
  logic [511:0]  red_a_q, red_a_d;
  logic [15:0]   wait_q, wait_d;
  logic          grant1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    busy_d      = busy_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = err_q;
    mul_start_d = mul_start_q;
    red_start_d = red_start_q;
    res_d       = res_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    red_a_d     = red_a_q;
    wait_d      = wait_q;
    grant1      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // last_q holds the previous owner; with both requesting, the other one wins.
          grant1      = (req0 && req1) ? ~last_q : req1;
          owner_d     = grant1;
          last_d      = grant1;
          mul_a_d     = grant1 ? a1 : a0;
          mul_b_d     = grant1 ? b1 : b0;
          mul_start_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = MUL_W1;
        end
      end
      MUL_W1: begin
        wait_d  = '0;
        state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (!mul_busy) begin
          red_a_d     = mul_c;
          mul_start_d = 1'b0;
          state_d     = RED_GO;
        end else if (wait_q == WAIT_LIMIT) begin
          err_d       = 1'b1;
          mul_start_d = 1'b0;
          red_start_d = 1'b0;
          res_d       = '0;
          ack0_d      = ~owner_q;
          ack1_d      = owner_q;
          state_d     = DONE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      RED_GO: begin
        red_start_d = 1'b1;
        state_d     = RED_W1;
      end
      RED_W1: begin
        wait_d  = '0;
        state_d = RED_WAIT;
      end
      RED_WAIT: begin
        if (!red_busy) begin
          res_d       = red_b;
          red_start_d = 1'b0;
          ack0_d      = ~owner_q;
          ack1_d      = owner_q;
          state_d     = DONE;
        end else if (wait_q == WAIT_LIMIT) begin
          err_d       = 1'b1;
          mul_start_d = 1'b0;
          red_start_d = 1'b0;
          res_d       = '0;
          ack0_d      = ~owner_q;
          ack1_d      = owner_q;
          state_d     = DONE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      mul_start_q <= 1'b0;
      red_start_q <= 1'b0;
      res_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      red_a_q     <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      mul_start_q <= mul_start_d;
      red_start_q <= red_start_d;
      res_q       <= res_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      red_a_q     <= red_a_d;
      wait_q      <= wait_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign res       = res_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign mul_start = mul_start_q;
  assign red_start = red_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign red_a     = red_a_q;

endmodule

// File: doc/mulred_sched.md
MULRED_SCHED -- requirements
Module: mulred_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023; max cycles allowed in any engine-wait state before abort.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1 each  requester 0 / 1 request; held high with operands stable until its ack
- a0 / b0  in  256 each  requester 0 operands
- a1 / b1  in  256 each  requester 1 operands
- ack0 / ack1  out  1 each  one-cycle completion pulse to requester 0 / 1
- res  out  256  result, valid while ack0 or ack1 is high, held until next ack
- busy  out  1  high from grant until end of the ack cycle
- err  out  1  sticky timeout flag
- mul_start  out  1  multiplier run level; low resets the multiplier
- mul_a / mul_b  out  256 each  multiplier operands
- mul_busy  in  1  multiplier busy
- mul_c  in  512  multiplier product
- red_start  out  1  reducer run level; low resets the reducer
- red_a  out  512  reducer input
- red_busy  in  1  reducer busy
- red_b  in  256  reduced result

Function
REQ-003 SHALL share one multiplier/reducer pair between two requesters, running each job as multiply then reduce: res = red_b for input mul_c = a*b.
REQ-004 SHALL implement states IDLE, MUL_W1, MUL_WAIT, RED_GO, RED_W1, RED_WAIT, DONE.
REQ-005 IDLE: if any req is high, SHALL grant one, latch mul_a/mul_b from it, set mul_start=1 and busy=1, record the grant owner, and go to MUL_W1.
REQ-006 Arbitration SHALL be round-robin: a single request wins; when both are high, the requester not served last wins; after reset, requester 0 has priority.
REQ-007 MUL_W1 SHALL unconditionally go to MUL_WAIT; engine busy lags start by one cycle and is ignored there.
REQ-008 MUL_WAIT with mul_busy=0: SHALL set red_a=mul_c and mul_start=0, then go to RED_GO.
REQ-009 RED_GO SHALL set red_start=1 and go to RED_W1.
REQ-010 RED_W1 SHALL go to RED_WAIT.
REQ-011 RED_WAIT with red_busy=0: SHALL set res=red_b and red_start=0, then go to DONE.
REQ-012 DONE: SHALL pulse the owner's ack for exactly one cycle, clear busy at its end, and return to IDLE; no grant is made in DONE.
REQ-013 Scheduler overhead SHALL be fixed: grant-to-ack = (MUL_WAIT cycles) + (RED_WAIT cycles) + 5.
REQ-014 mul_start and red_start SHALL never be high simultaneously.
REQ-015 A 16-bit wait counter SHALL clear on entry to MUL_WAIT and RED_WAIT and increment each cycle spent there.
REQ-016 When the wait counter reaches TIMEOUT, SHALL:
- set err=1
- drive both start outputs low
- set res=0
- go to DONE, where the owner is acked normally
REQ-017 err SHALL stay high until rst; jobs after an error SHALL still be accepted.
REQ-018 A req dropping before its ack SHALL NOT abort the job; the job completes and is acked.
REQ-019 Operand inputs SHALL be sampled only at grant.

Reset
REQ-020 rst high SHALL immediately force:
- state=IDLE
- busy, ack0, ack1, err, mul_start, red_start = 0
- res, mul_a, mul_b, red_a = 0
- round-robin pointer to requester 0 priority
REQ-021 rst mid-job SHALL discard the job with no ack; the requester re-requests.

Verification
REQ-022 Single job: req0, a0=2, b0=3, behavioral engines -> one ack0 pulse, res=6, ack1 never asserted.
REQ-023 Wrap reduction: req1, a1=2^255, b1=2 -> mul_c=2^256, red_a=2^256, res=0x1000003D1.
REQ-024 Contention: req0 and req1 rise in the same cycle and are held -> order ack0, ack1, ack0, ack1; mul_start and red_start never both high.
REQ-025 Timeout: mul_busy stuck at 1, TIMEOUT=8 -> err=1 after 8 MUL_WAIT cycles, ack0 pulses with res=0; the next job then completes normally with err still 1.
REQ-026 Reset mid-operation: rst pulsed during RED_WAIT -> all outputs 0 asynchronously, no ack; a later req0 completes correctly.
REQ-027 Latency: engines with 19-cycle mul busy and 9-cycle red busy -> grant-to-ack equals 19+9+5 cycles exactly, per REQ-013.
